crc_serial_engine: RTL and testbench
====================================

Name: crc_serial_engine

Overview:
- Parametrised, handshaked successor to the board-level serial CRC state machine.
- Accepts a DATA_W-bit word on a START pulse and shifts it MSB-first through a CRC_W-bit LFSR, one bit per clock.
- Presents the final CRC (optionally XOR-masked) with a one-cycle DONE pulse.
- Supports chaining words into one multi-word message. Sits between switch/data capture logic and LED or display output.

Parameters:
- DATA_W, 16, message word width in bits (>=1).
- CRC_W, 16, CRC register width in bits (2..32).
- POLY, 'h1021, generator polynomial, implicit x^CRC_W term omitted, CRC_W bits.
- INIT, 'h0000, CRC register value loaded at start of a new message.
- XOR_OUT, 'h0000, mask XORed into the result when presented on CRC_OUT.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  synchronous active-low reset.
- START  in  1  request to process DATA_IN; sampled only in IDLE.
- CONT  in  1  sampled with START. 1 = continue from the current CRC register (chained word); 0 = load INIT.
- DATA_IN  in  DATA_W  message word; captured on the accepted START edge.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle pulse; CRC_OUT is valid and updated.
- CRC_OUT  out  CRC_W  result (crc_reg ^ XOR_OUT); held until the next DONE.

Behaviour:
- Single clock CLK; reset RESET_N is synchronous, active-low. Fixed.
- Reset values: state=IDLE, BUSY=0, DONE=0, CRC_OUT=0, crc_reg=0, shift register=0, bit counter=0.
- States:
  - IDLE: on START=1, capture DATA_IN into the shift register. Set crc_reg <= (CONT ? crc_reg : INIT), bit counter <= 0, go to SHIFT.
  - SHIFT: each edge consumes bit b = shift register MSB, shifts the register left by 1, and increments the counter. Update rule (direct, non-augmented form): fb = crc_reg[CRC_W-1] ^ b; crc_reg <= {crc_reg[CRC_W-2:0],0} ^ (fb ? POLY : 0). On the edge consuming the last bit (counter == DATA_W-1), compute next crc_reg, load CRC_OUT <= next crc_reg ^ XOR_OUT, and go to FINISH.
  - FINISH: DONE=1 (registered Moore output), BUSY=1. Next edge returns to IDLE unconditionally.
- Latency: START accepted at edge 0; DONE high for exactly one cycle after edge DATA_W. Back-to-back throughput is one word per DATA_W+2 cycles.
- Equivalence: for INIT=0, the result equals the augmented method (message followed by CRC_W zero bits).
- crc_reg is not cleared on DONE; it persists so a following START with CONT=1 chains.
- Boundary conditions:
  - START while BUSY (SHIFT or FINISH) is ignored entirely, and DATA_IN is not captured.
  - START held high continuously restarts in the cycle after FINISH, using the DATA_IN present then.
  - CONT is ignored unless START is accepted.
  - CONT=1 on the first word after reset continues from crc_reg=0, not from INIT.
  - RESET_N low mid-SHIFT: next edge forces the reset values. No DONE is produced and CRC_OUT is cleared to 0.
  - Bit counter width is $clog2(DATA_W+1); no wrap is possible inside SHIFT.
  - DATA_W=1: SHIFT lasts exactly one edge.
- Width rules: POLY, INIT and XOR_OUT are truncated or zero-extended to CRC_W. All arithmetic is GF(2) XOR with no carries.

Decomposition:
- Package crc_pkg: state enum {IDLE, SHIFT, FINISH}, and function crc_step(crc, bit, poly) returning the next CRC value.
- No sub-module needed; the LFSR step is the package function used inline.

Test Plan:
- Defaults (CRC-16/XMODEM form), single words: DATA_IN=0x0001, START -> DONE exactly 16 cycles after START edge, CRC_OUT=0x1021. DATA_IN=0x0002 -> 0x2042. DATA_IN=0x0003 -> 0x3063. DATA_IN=0x0000 -> 0x0000.
- Chaining: 0x0000 with CONT=0, then 0x0001 with CONT=1 -> final CRC_OUT=0x1021 (32-bit message 0x00000001). First DONE shows 0x0000.
- XOR_OUT=0xFFFF, DATA_IN=0x0001 -> CRC_OUT=0xEFDE. BUSY high from edge after START through the FINISH cycle.
- CRC_W=8, DATA_W=8, POLY=0x07, DATA_IN=0x01 -> CRC_OUT=0x07 with DONE 8 cycles after START.
- START re-pulsed with different DATA_IN during SHIFT -> ignored, result unchanged (0x1021 for 0x0001). Then RESET_N low for one cycle mid-SHIFT of a second word -> no DONE, CRC_OUT=0, BUSY=0 after the edge.
- Randomised check: 200 random words with random CONT against a bit-serial reference model, comparing CRC_OUT and DONE timing exactly.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and the single-bit LFSR step for the serial CRC engine.
// Latency: combinational helper only.
// Backpressure: not applicable (no handshake in this file).
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } crc_state_e;

   // One MSB-first step of the direct (non-augmented) CRC form.
   // Works on a 32-bit container; width selects the live register size (2..32).
   function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                            input logic        din,
                                            input logic [31:0] poly,
                                            input int          width);
      logic [31:0] mask;
      logic [31:0] nxt;
      logic        fb;
      mask = 32'hFFFF_FFFF >> (32 - width);
      fb   = (|(crc & (32'h1 << (width - 1)))) ^ din;
      nxt  = {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0);
      return nxt & mask;
   endfunction

endpackage

// File: rtl/crc_serial_engine.sv
// Serial MSB-first CRC over one DATA_W word per START, with optional chaining.
// Latency: START accepted at edge 0, DONE pulses for one cycle after edge DATA_W.
// Backpressure: START is ignored while BUSY; DONE/CRC_OUT never stall, so the consumer must capture on DONE.
module crc_serial_engine
   import crc_pkg::*;
#(
   parameter int          DATA_W  = 16,
   parameter int          CRC_W   = 16,
   parameter logic [31:0] POLY    = 32'h1021,
   parameter logic [31:0] INIT    = 32'h0000,
   parameter logic [31:0] XOR_OUT = 32'h0000
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic              CONT,
   input  logic [DATA_W-1:0] DATA_IN,
   output logic              BUSY,
   output logic              DONE,
   output logic [CRC_W-1:0]  CRC_OUT
);

   localparam int               CNT_W  = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(DATA_W - 1);
   localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
   localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] XOR_C  = XOR_OUT[CRC_W-1:0];

   crc_state_e        state;
   logic [CRC_W-1:0]  crc_reg;
   logic [CRC_W-1:0]  crc_next;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;

   // Next CRC value if the current shift-register MSB is consumed this edge.
   assign crc_next = CRC_W'(crc_step(32'(crc_reg), shreg[DATA_W-1], 32'(POLY_C), CRC_W));

   // Status outputs decode directly from the state register, so both are glitch-free Moore outputs.
   assign BUSY = (state != IDLE);
   assign DONE = (state == FINISH);

   // Control FSM plus datapath: capture word, shift one bit per edge, publish result.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state   <= IDLE;
         crc_reg <= '0;
         shreg   <= '0;
         cnt     <= '0;
         CRC_OUT <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  shreg   <= DATA_IN;
                  // crc_reg is kept across words so CONT can chain a longer message.
                  crc_reg <= CONT ? crc_reg : INIT_C;
                  cnt     <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               crc_reg <= crc_next;
               shreg   <= shreg << 1;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  CRC_OUT <= crc_next ^ XOR_C;
                  state   <= FINISH;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed and model-based bench for crc_serial_engine over four parameter sets.
// Latency: checks DONE arrival cycle exactly against DATA_W.
// Backpressure: exercises START while BUSY, START held high, and mid-word reset.
module tb_crc_serial_engine;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   // Instance 0: defaults (XMODEM form)
   logic        st0, ct0, busy0, done0;
   logic [15:0] d0, crc0;
   // Instance 1: XOR_OUT = 0xFFFF
   logic        st1, ct1, busy1, done1;
   logic [15:0] d1, crc1;
   // Instance 2: 8-bit word, 8-bit CRC, poly 0x07
   logic        st2, ct2, busy2, done2;
   logic [7:0]  d2, crc2;
   // Instance 3: 1-bit word, 8-bit CRC, poly 0x07
   logic        st3, ct3, busy3, done3;
   logic [0:0]  d3;
   logic [7:0]  crc3;

   int n_total = 0;
   int n_bad   = 0;

   crc_serial_engine u_dut (
      .CLK(clk), .RESET_N(reset_n), .START(st0), .CONT(ct0), .DATA_IN(d0),
      .BUSY(busy0), .DONE(done0), .CRC_OUT(crc0));

   crc_serial_engine #(.XOR_OUT(32'hFFFF)) u_xor (
      .CLK(clk), .RESET_N(reset_n), .START(st1), .CONT(ct1), .DATA_IN(d1),
      .BUSY(busy1), .DONE(done1), .CRC_OUT(crc1));

   crc_serial_engine #(.DATA_W(8), .CRC_W(8), .POLY(32'h07)) u_c8 (
      .CLK(clk), .RESET_N(reset_n), .START(st2), .CONT(ct2), .DATA_IN(d2),
      .BUSY(busy2), .DONE(done2), .CRC_OUT(crc2));

   crc_serial_engine #(.DATA_W(1), .CRC_W(8), .POLY(32'h07)) u_w1 (
      .CLK(clk), .RESET_N(reset_n), .START(st3), .CONT(ct3), .DATA_IN(d3),
      .BUSY(busy3), .DONE(done3), .CRC_OUT(crc3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit-serial CRC-16/XMODEM reference, MSB first.
   function automatic logic [15:0] m16(input logic [15:0] crc, input logic [15:0] d);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   task automatic set_in(input int inst, input logic s, input logic [31:0] d, input logic c);
      case (inst)
         0: begin st0 = s; d0 = d[15:0]; ct0 = c; end
         1: begin st1 = s; d1 = d[15:0]; ct1 = c; end
         2: begin st2 = s; d2 = d[7:0];  ct2 = c; end
         default: begin st3 = s; d3 = d[0:0]; ct3 = c; end
      endcase
   endtask

   function automatic logic get_done(input int inst);
      case (inst)
         0: return done0;
         1: return done1;
         2: return done2;
         default: return done3;
      endcase
   endfunction

   function automatic logic get_busy(input int inst);
      case (inst)
         0: return busy0;
         1: return busy1;
         2: return busy2;
         default: return busy3;
      endcase
   endfunction

   function automatic logic [31:0] get_crc(input int inst);
      case (inst)
         0: return {16'h0, crc0};
         1: return {16'h0, crc1};
         2: return {24'h0, crc2};
         default: return {24'h0, crc3};
      endcase
   endfunction

   // One word from IDLE: checks BUSY after accept, DONE latency, result, and the single-cycle pulse.
   // repulse>0 re-asserts START with different data/CONT during SHIFT at that cycle.
   task automatic run_word(input int inst, input logic [31:0] d, input logic c, input int repulse,
                           input int exp_lat, input logic [31:0] exp_crc, input string tag);
      int lat;
      lat = -1;
      @(negedge clk);
      set_in(inst, 1'b1, d, c);
      @(posedge clk); #1;
      set_in(inst, 1'b0, d, c);
      chk({tag, "_busy_acc"}, 32'(get_busy(inst)), 32'd1);
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (get_done(inst)) begin
            lat = k;
            break;
         end
         if (repulse != 0 && k == repulse)
            set_in(inst, 1'b1, ~d, ~c);
         else if (repulse != 0 && k == repulse + 1)
            set_in(inst, 1'b0, d, c);
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_crc"}, get_crc(inst), exp_crc);
      chk({tag, "_busy_fin"}, 32'(get_busy(inst)), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(get_done(inst)), 32'd0);
      chk({tag, "_busy_idle"}, 32'(get_busy(inst)), 32'd0);
   endtask

   initial begin
      int          lat;
      int          ndone;
      logic [15:0] mcrc;
      logic [15:0] rd;
      logic        rc;

      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) set_in(i, 1'b0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_crc", {16'h0, crc0}, 32'h0);
      chk("rst_crc8", {24'h0, crc2}, 32'h0);
      reset_n = 1'b1;

      // Single words, defaults
      run_word(0, 32'h0001, 1'b0, 0, 16, 32'h1021, "w0001");
      run_word(0, 32'h0002, 1'b0, 0, 16, 32'h2042, "w0002");
      run_word(0, 32'h0003, 1'b0, 0, 16, 32'h3063, "w0003");
      run_word(0, 32'h0000, 1'b0, 0, 16, 32'h0000, "w0000");

      // Chaining: message 0x00000001
      run_word(0, 32'h0000, 1'b0, 0, 16, 32'h0000, "chain_a");
      run_word(0, 32'h0001, 1'b1, 0, 16, 32'h1021, "chain_b");

      // Output mask, 8-bit CRC, 1-bit word
      run_word(1, 32'h0001, 1'b0, 0, 16, 32'hEFDE, "xor");
      run_word(2, 32'h01, 1'b0, 0, 8, 32'h07, "c8");
      run_word(3, 32'h1, 1'b0, 0, 1, 32'h07, "w1");

      // START during SHIFT must be ignored
      run_word(0, 32'h0001, 1'b0, 4, 16, 32'h1021, "busy_start");

      // START held high: restarts right after FINISH with the data present then
      @(negedge clk);
      set_in(0, 1'b1, 32'h0001, 1'b0);
      @(posedge clk); #1;
      d0 = 16'h0002;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done0) begin lat = k; break; end
      end
      chk("hold_lat1", 32'(lat), 32'd16);
      chk("hold_crc1", {16'h0, crc0}, 32'h1021);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done0) begin lat = k; break; end
      end
      st0 = 1'b0;
      chk("hold_lat2", 32'(lat), 32'd18);
      chk("hold_crc2", {16'h0, crc0}, 32'h2042);
      @(posedge clk); #1;
      chk("hold_idle", 32'(busy0), 32'd0);

      // Reset mid-SHIFT
      @(negedge clk);
      set_in(0, 1'b1, 32'h0001, 1'b0);
      @(posedge clk); #1;
      st0 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("mrst_busy", 32'(busy0), 32'd0);
      chk("mrst_done", 32'(done0), 32'd0);
      chk("mrst_crc", {16'h0, crc0}, 32'h0);
      reset_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (done0) ndone++;
      end
      chk("mrst_no_done", 32'(ndone), 32'd0);

      // CONT=1 right after reset continues from a cleared register
      run_word(0, 32'h0003, 1'b1, 0, 16, 32'h3063, "cont_first");

      // Random words against the reference model
      mcrc = 16'h0;
      for (int i = 0; i < 200; i++) begin
         rd   = 16'($urandom_range(0, 65535));
         rc   = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         mcrc = m16(rc ? mcrc : 16'h0000, rd);
         run_word(0, {16'h0, rd}, rc, 0, 16, {16'h0, mcrc}, "rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
